// File: rtl/spi_lcd_master.sv
// Mode-0 MSB-first SPI master with D/C framing for the LCD PMOD.
// Define SPI_BURST_EN to chain back-to-back words inside one chip-select frame.
module spi_lcd_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dc_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              dc
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

`ifdef SPI_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic              go_q, go_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dc_lat_q, dc_lat_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              dc_q, dc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W:0]   rx_cat;
    logic              div_end;

    assign tx_sh   = tx_q << 1;
    assign rx_cat  = {rx_q, miso};
    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        go_d     = go_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        dc_lat_d = dc_lat_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        dc_d     = dc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Word is latched on acceptance, frame opens one cycle later.
                if (go_q) begin
                    go_d    = 1'b0;
                    state_d = SETUP;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    dc_d    = dc_lat_q;
                    mosi_d  = tx_q[DATA_W-1];
                end else if (start) begin
                    go_d     = 1'b1;
                    tx_d     = data_in;
                    dc_lat_d = dc_in;
                end
            end
            SETUP: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    rx_d    = rx_cat[DATA_W-1:0];
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_q != BIT_LAST) begin
                            tx_d   = tx_sh;
                            mosi_d = tx_sh[DATA_W-1];
                        end
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sck_d = 1'b1;
                        rx_d  = rx_cat[DATA_W-1:0];
                    end
                end
            end
            default: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    div_d  = '0;
                    done_d = 1'b1;
                    dout_d = rx_q;
                    if (BURST && start) begin
                        state_d  = SETUP;
                        tx_d     = data_in;
                        dc_lat_d = dc_in;
                        dc_d     = dc_in;
                        mosi_d   = data_in[DATA_W-1];
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        cs_n_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            go_q     <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            dc_lat_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            dc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            dc_lat_q <= dc_lat_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            dc_q     <= dc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data_out = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign dc       = dc_q;

endmodule

// File: tb/tb_spi_lcd_master.sv
// Directed bench for spi_lcd_master: framing, latency, loopback and slave receive.
// Burst section runs only when SPI_BURST_EN is defined.
module tb_spi_lcd_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       dc_in = 1'b0;
    logic [7:0] data_out;
    logic       busy, done, sck, mosi, cs_n, dc;
    wire        miso;

    logic       loop_en = 1'b1;
    logic [7:0] sl_pat = 8'h00;
    logic [7:0] sl_sr = 8'h00;
    logic       exp_dc = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int n_done = 0;
    int n_frame = 0;
    int n_csrise = 0;
    int n_rise = 0;
    int dc_bad = 0;
    logic [7:0] cap = 8'h00;

    spi_lcd_master dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .dc_in    (dc_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n),
        .dc       (dc)
    );

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : sl_sr[7];

    always @(posedge clk) begin
        cyc++;
        if (done) n_done++;
    end

    always @(negedge cs_n) begin
        n_frame++;
        sl_sr = sl_pat;
    end

    always @(posedge cs_n) n_csrise++;

    always @(negedge sck) sl_sr = sl_sr << 1;

    always @(posedge sck) begin
        cap = {cap[6:0], mosi};
        n_rise++;
        if (dc !== exp_dc) dc_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_rise = 0;
        dc_bad = 0;
        cap    = 8'h00;
    endtask

    task automatic launch(input logic [7:0] d, input logic dcv);
        @(negedge clk);
        data_in = d;
        dc_in   = dcv;
        exp_dc  = dcv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) $display("FAIL timeout: no done within 300 cycles");
    endtask

    initial begin
        int lat;
        int nd, nf;

        // reset held with start asserted
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_dc", dc, 1'b0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // single write, loopback
        clr_mon();
        loop_en = 1'b1;
        launch(8'hA5, 1'b1);
        chk("a5_busy_t0", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("a5_busy_t1", busy, 1'b1);
        chk("a5_cs_t1", cs_n, 1'b0);
        chk("a5_dc_t1", dc, 1'b1);
        chk("a5_mosi_t1", mosi, 1'b1);
        wait_done(lat);
        chk("a5_lat", lat, 73);
        chk("a5_dout", data_out, 8'hA5);
        chk("a5_rises", n_rise, 8);
        chk("a5_mosi_bits", cap, 8'hA5);
        chk("a5_dc_stable", dc_bad, 0);
        chk("a5_busy_end", busy, 1'b0);
        chk("a5_cs_end", cs_n, 1'b1);
        @(posedge clk);
        #1;
        chk("a5_done_pulse", done, 1'b0);
        chk("a5_dout_hold", data_out, 8'hA5);

        // receive from slave while sending zeros
        repeat (3) @(posedge clk);
        clr_mon();
        loop_en = 1'b0;
        sl_pat  = 8'h3C;
        launch(8'h00, 1'b0);
        wait_done(lat);
        chk("rx_lat", lat, 73);
        chk("rx_dout", data_out, 8'h3C);
        chk("rx_mosi_bits", cap, 8'h00);
        chk("rx_dc_stable", dc_bad, 0);

        // start while busy is ignored
        repeat (3) @(posedge clk);
        clr_mon();
        loop_en = 1'b1;
        nd = n_done;
        nf = n_frame;
        launch(8'h96, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        data_in = 8'hFF;
        dc_in   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("bz_lat", lat, 73);
        chk("bz_dout", data_out, 8'h96);
        repeat (100) @(posedge clk);
        #1;
        chk("bz_frames", n_frame - nf, 1);
        chk("bz_dones", n_done - nd, 1);
        chk("bz_mosi_bits", cap, 8'h96);

        // reset in the middle of a frame
        nd = n_done;
        launch(8'h5A, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mr_cs_n", cs_n, 1'b1);
        chk("mr_sck", sck, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_dout", data_out, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("mr_no_done", n_done - nd, 0);
        chk("mr_idle_cs", cs_n, 1'b1);
        clr_mon();
        launch(8'h81, 1'b1);
        wait_done(lat);
        chk("mr_lat", lat, 73);
        chk("mr_dout_81", data_out, 8'h81);
        chk("mr_mosi_bits", cap, 8'h81);

`ifdef SPI_BURST_EN
        // two words chained in one frame
        repeat (3) @(posedge clk);
        nf = n_frame;
        nd = n_csrise;
        @(negedge clk);
        data_in = 8'h11;
        dc_in   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        t0      = cyc;
        data_in = 8'h22;
        dc_in   = 1'b1;
        wait_done(lat);
        start = 1'b0;
        chk("bu_lat1", lat, 73);
        chk("bu_dout1", data_out, 8'h11);
        chk("bu_cs_mid", cs_n, 1'b0);
        chk("bu_busy_mid", busy, 1'b1);
        chk("bu_dc_mid", dc, 1'b1);
        wait_done(lat);
        chk("bu_lat2", lat, 145);
        chk("bu_dout2", data_out, 8'h22);
        chk("bu_frames", n_frame - nf, 1);
        chk("bu_cs_rises", n_csrise - nd, 1);
`endif

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
